// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared fetch-stage types and constants.
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] c_NOP_INST = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_id_reg_en.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg_en
// Description : IF/ID pipeline register with enable and flush-to-NOP.
// Revision    : 1.0  initial release
// ============================================================================
module if_id_reg_en
    import pipeline_pkg::*;
#(
    parameter int                     PC_WIDTH   = 11,
    parameter int                     INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]  NOP_INST   = INST_WIDTH'(c_NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_valid,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_valid
);

    logic [PC_WIDTH-1:0]   r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_valid;

    // Flush keeps the PC field so decode still sees where the bubble came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_hs.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_hs
// Description : Fetch stage with req/ready imem handshake, stall skid and redirect.
// Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_hs
    import pipeline_pkg::*;
#(
    parameter int                     PC_WIDTH   = 11,
    parameter int                     INST_WIDTH = 32,
    parameter int                     PC_STEP    = 1,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]  NOP_INST   = INST_WIDTH'(c_NOP_INST)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   pc_salto,
    input  logic                  PCSrc,
    input  logic                  if_id_write,
    input  logic                  if_flush,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] instruccion,
    output logic                  valid
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [PC_WIDTH-1:0]   r_pc_actual;
    logic [PC_WIDTH-1:0]   w_pc_actual_next;
    logic [PC_WIDTH-1:0]   r_drain_addr;
    logic [PC_WIDTH-1:0]   w_pc_inc;
    logic [INST_WIDTH-1:0] r_skid;
    logic [INST_WIDTH-1:0] w_ifid_inst;
    logic                  w_skid_load;
    logic                  w_drain_load;
    logic                  w_load_mem;
    logic                  w_load_skid;
    logic                  w_deliver_ok;

    assign w_pc_inc     = r_pc_actual + PC_WIDTH'(PC_STEP);
    assign w_deliver_ok = if_id_write & ~if_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= START;
            r_pc_actual  <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_skid       <= NOP_INST;
        end else begin
            r_state     <= w_state_next;
            r_pc_actual <= w_pc_actual_next;
            if (PCSrc) begin
                r_skid <= NOP_INST;
            end else if (w_skid_load) begin
                r_skid <= imem_data;
            end
            if (w_drain_load) begin
                r_drain_addr <= r_pc_actual;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_actual_next = r_pc_actual;
        w_skid_load      = 1'b0;
        w_drain_load     = 1'b0;
        w_load_mem       = 1'b0;
        w_load_skid      = 1'b0;
        imem_req         = 1'b0;
        imem_addr        = r_pc_actual;
        case (r_state)
            START: begin
                w_state_next = FETCH;
                if (PCSrc) begin
                    w_pc_actual_next = pc_salto;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (PCSrc) begin
                    w_pc_actual_next = pc_salto;
                    if (imem_ready) begin
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = DRAIN;
                        w_drain_load = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (w_deliver_ok) begin
                        w_load_mem       = 1'b1;
                        w_pc_actual_next = w_pc_inc;
                    end else begin
                        // Stalled or flushed delivery parks in the skid buffer.
                        w_skid_load  = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    w_pc_actual_next = pc_salto;
                    w_state_next     = FETCH;
                end else if (w_deliver_ok) begin
                    w_load_skid      = 1'b1;
                    w_pc_actual_next = w_pc_inc;
                    w_state_next     = FETCH;
                end
            end
            DRAIN: begin
                // Keep the stale request alive until memory answers, then drop its data.
                imem_req  = 1'b1;
                imem_addr = r_drain_addr;
                if (PCSrc) begin
                    w_pc_actual_next = pc_salto;
                end
                if (imem_ready) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = START;
            end
        endcase
    end

    assign w_ifid_inst = w_load_skid ? r_skid : imem_data;

    if_id_reg_en #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .NOP_INST   (NOP_INST)
    ) u_if_id (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_load_mem | w_load_skid),
        .i_flush (if_flush),
        .i_pc    (w_pc_inc),
        .i_inst  (w_ifid_inst),
        .i_valid (1'b1),
        .o_pc    (pc),
        .o_inst  (instruccion),
        .o_valid (valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_hs
// Description : Scoreboard bench for instruction_fetch_hs with a gated-latency memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_hs;

    logic        clock;
    logic        reset;
    logic [10:0] pc_salto;
    logic        PCSrc;
    logic        if_id_write;
    logic        if_flush;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [10:0] pc;
    logic [31:0] instruccion;
    logic        valid;

    logic        reset_w;
    logic        imem_req_w;
    logic [10:0] imem_addr_w;
    logic        imem_ready_w;
    logic [31:0] imem_data_w;
    logic [10:0] pc_w;
    logic [31:0] instr_w;
    logic        valid_w;

    int n_checks = 0;
    int n_fail   = 0;

    int mem_lat        = 0;
    int grants_allowed = 0;
    int grants_done    = 0;
    int wait_cnt       = 0;

    logic [10:0] q_addr[$];
    logic [10:0] q_pc[$];
    logic [31:0] q_inst[$];

    logic        prev_req;
    logic        prev_ready;
    logic [10:0] prev_addr;
    logic        last_valid;
    logic [10:0] last_pc;
    logic [31:0] last_inst;

    instruction_fetch_hs dut (
        .clock       (clock),
        .reset       (reset),
        .pc_salto    (pc_salto),
        .PCSrc       (PCSrc),
        .if_id_write (if_id_write),
        .if_flush    (if_flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .pc          (pc),
        .instruccion (instruccion),
        .valid       (valid)
    );

    instruction_fetch_hs #(.RESET_PC(11'h7FF)) dut_w (
        .clock       (clock),
        .reset       (reset_w),
        .pc_salto    (11'h000),
        .PCSrc       (1'b0),
        .if_id_write (1'b1),
        .if_flush    (1'b0),
        .imem_req    (imem_req_w),
        .imem_addr   (imem_addr_w),
        .imem_ready  (imem_ready_w),
        .imem_data   (imem_data_w),
        .pc          (pc_w),
        .instruccion (instr_w),
        .valid       (valid_w)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory returns addr*16; ready only while grants remain and latency has elapsed.
    assign imem_ready   = imem_req && (grants_done < grants_allowed) && (wait_cnt >= mem_lat);
    assign imem_data    = {17'b0, imem_addr, 4'b0};
    assign imem_ready_w = imem_req_w;
    assign imem_data_w  = {17'b0, imem_addr_w, 4'b0};

    always @(posedge clock) begin
        if (imem_req && (grants_done < grants_allowed)) begin
            if (imem_ready) begin
                wait_cnt    <= 0;
                grants_done <= grants_done + 1;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_out(input logic [10:0] p, input logic [31:0] i);
        q_pc.push_back(p);
        q_inst.push_back(i);
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clock);
            #1;
            if (q_addr.size() == 0 && q_pc.size() == 0) break;
        end
        check("sb_addr_left", q_addr.size(), 0);
        check("sb_out_left", q_pc.size(), 0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_req   <= 1'b0;
            prev_ready <= 1'b0;
            last_valid <= 1'b0;
        end else begin
            if (prev_req && !prev_ready && imem_req) begin
                check("addr_hold", imem_addr, prev_addr);
            end
            if (imem_req && imem_ready) begin
                if (q_addr.size() == 0) check("sb_addr_underflow", q_addr.size(), 1);
                else check("fetch_addr", imem_addr, q_addr.pop_front());
            end
            if (valid && (!last_valid || pc != last_pc || instruccion != last_inst)) begin
                if (q_pc.size() == 0) begin
                    check("sb_out_underflow", q_pc.size(), 1);
                end else begin
                    check("ifid_pc", pc, q_pc.pop_front());
                    check("ifid_inst", instruccion, q_inst.pop_front());
                end
            end
            prev_req   <= imem_req;
            prev_ready <= imem_ready;
            prev_addr  <= imem_addr;
            last_valid <= valid;
            last_pc    <= pc;
            last_inst  <= instruccion;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        reset_w     = 1'b1;
        pc_salto    = 11'h000;
        PCSrc       = 1'b0;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pc", pc, 0);
        check("rst_inst", instruccion, 0);
        check("rst_valid", valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_w_req", imem_req_w, 0);

        // Zero-wait streaming: 4 back-to-back fetches
        @(posedge clock); #1;
        reset = 1'b0;
        grants_allowed += 4;
        for (int a = 0; a < 4; a++) begin
            q_addr.push_back(11'(a));
            push_out(11'(a + 1), 32'(a * 16));
        end
        @(negedge clock);
        check("start_req", imem_req, 0);
        @(negedge clock);
        check("first_valid", valid, 0);
        @(negedge clock);
        check("second_valid", valid, 1);
        wait_empty(10);

        // Three-cycle memory latency
        mem_lat = 2;
        grants_allowed += 3;
        for (int a = 4; a < 7; a++) begin
            q_addr.push_back(11'(a));
            push_out(11'(a + 1), 32'(a * 16));
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            check("lat_valid", valid, 1);
        end
        wait_empty(20);

        // Stall: delivery parked in skid while if_id_write is low
        mem_lat = 0;
        if_id_write = 1'b0;
        grants_allowed += 1;
        q_addr.push_back(11'd7);
        push_out(11'd8, 32'h70);
        push_out(11'd9, 32'h80);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("hold_req", imem_req, 0);
            check("hold_pc", pc, 7);
            check("hold_inst", instruccion, 32'h60);
            check("hold_valid", valid, 1);
        end
        @(posedge clock); #1;
        if_id_write = 1'b1;
        grants_allowed += 1;
        q_addr.push_back(11'd8);
        wait_empty(10);

        // Redirect while fetch of 0x009 is outstanding
        pc_salto = 11'h200;
        PCSrc    = 1'b1;
        @(posedge clock); #1;
        PCSrc = 1'b0;
        @(negedge clock);
        check("drain_req", imem_req, 1);
        check("drain_addr", imem_addr, 11'h009);
        check("drain_pc", pc, 11'h009);
        check("drain_valid", valid, 1);
        @(negedge clock);
        check("drain_addr2", imem_addr, 11'h009);
        @(posedge clock); #1;
        grants_allowed += 3;
        q_addr.push_back(11'h009);
        q_addr.push_back(11'h200);
        q_addr.push_back(11'h201);
        push_out(11'h201, 32'h2000);
        push_out(11'h202, 32'h2010);
        wait_empty(10);

        // One-cycle flush
        if_flush = 1'b1;
        @(posedge clock); #1;
        if_flush = 1'b0;
        @(negedge clock);
        check("flush_inst", instruccion, 0);
        check("flush_valid", valid, 0);
        check("flush_pc", pc, 11'h202);
        check("flush_req", imem_req, 1);
        @(posedge clock); #1;
        grants_allowed += 1;
        q_addr.push_back(11'h202);
        push_out(11'h203, 32'h2020);
        wait_empty(10);

        // Reset while a fetch is pending
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_req", imem_req, 0);
        check("midrst_valid", valid, 0);
        check("midrst_pc", pc, 0);

        // PC wrap from RESET_PC = 0x7FF
        @(posedge clock); #1;
        reset_w = 1'b0;
        @(negedge clock);
        check("wrap_start_req", imem_req_w, 0);
        @(negedge clock);
        check("wrap_req", imem_req_w, 1);
        check("wrap_addr0", imem_addr_w, 11'h7FF);
        @(negedge clock);
        check("wrap_addr1", imem_addr_w, 11'h000);
        check("wrap_pc1", pc_w, 11'h000);
        check("wrap_inst1", instr_w, 32'h7FF0);
        check("wrap_valid1", valid_w, 1);
        @(negedge clock);
        check("wrap_addr2", imem_addr_w, 11'h001);
        check("wrap_pc2", pc_w, 11'h001);
        check("wrap_inst2", instr_w, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
